jk_bank_driver: RTL and testbench

- Control-side counterpart of the JK flip-flop: accepts target register values over a valid/ready handshake.
- Converts each target into per-bit J/K excitation using the current flop outputs, drives a bank of WIDTH JK flip-flops for exactly one cycle, then reads back q and checks it.
- Reports done or error, with bounded retry.
- Sits between a command source (sequencer/bench) and a JK flip-flop bank built from the existing flop cell.

---
 rtl/jk_bank_driver_if.sv | 15 +
 rtl/jk_bank_driver.sv | 118 +++++++++++
 tb/tb_jk_bank_driver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_driver_if.sv
// jk_bank_driver_if: target handshake between a command source and jk_bank_driver.
//   tgt_valid : source has a target value on tgt_data
//   tgt_ready : driver can accept a target
//   tgt_data  : requested q value for the flop bank (WIDTH bits)
// Modports: master = command source, slave = jk_bank_driver.
interface jk_bank_driver_if #(
  parameter int WIDTH = 4
) ();
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: accepts target register values and drives a bank of WIDTH
// JK flip-flops for one cycle per attempt to reach each target. After SETTLE
// cycles it reads q back. On a match it pulses done. On a mismatch it
// re-drives, up to MAX_RETRY times, and then pulses err.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   tgt        target handshake (slave): tgt_valid / tgt_ready / tgt_data
//   q_in       q outputs fed back from the flop bank
//   j_out      J inputs to the flop bank (registered)
//   k_out      K inputs to the flop bank (registered)
//   done       one-cycle pulse: q_in matched the target
//   err        one-cycle pulse: retries exhausted, still mismatched
//   retry_cnt  retries used by the current/last request
//
// Build option: define JK_TOGGLE_EN to drive changing bits as j=k=1 (toggle)
// instead of set/reset. Handshake, latency and checking are the same in both builds.
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_driver_if.slave  tgt,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             done,
  output logic             err,
  output logic [3:0]       retry_cnt
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [CW-1:0]    settle_cnt;

  logic [WIDTH-1:0] exc_tgt;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  // Excitation is registered on DRIVE entry. From IDLE the target is not
  // latched yet, so it comes straight from the bus. On a retry it comes from
  // the latched copy.
  always_comb begin
    exc_tgt = (state == IDLE) ? tgt.tgt_data : target;
`ifdef JK_TOGGLE_EN
    exc_j   = q_in ^ exc_tgt;
    exc_k   = q_in ^ exc_tgt;
`else
    exc_j   = ~q_in & exc_tgt;
    exc_k   = q_in & ~exc_tgt;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      target        <= '0;
      settle_cnt    <= '0;
      j_out         <= '0;
      k_out         <= '0;
      tgt.tgt_ready <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
      retry_cnt     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          j_out         <= '0;
          k_out         <= '0;
          tgt.tgt_ready <= 1'b1;
          if (tgt.tgt_valid && tgt.tgt_ready) begin
            target        <= tgt.tgt_data;
            retry_cnt     <= '0;
            j_out         <= exc_j;
            k_out         <= exc_k;
            tgt.tgt_ready <= 1'b0;
            state         <= DRIVE;
          end
        end
        DRIVE: begin
          j_out      <= '0;
          k_out      <= '0;
          settle_cnt <= CW'(SETTLE - 1);
          state      <= CHECK;
        end
        CHECK: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CW'(1);
          end else if (q_in == target) begin
            done          <= 1'b1;
            tgt.tgt_ready <= 1'b1;
            state         <= IDLE;
          end else if (retry_cnt < 4'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 4'd1;
            j_out     <= exc_j;
            k_out     <= exc_k;
            state     <= DRIVE;
          end else begin
            err           <= 1'b1;
            tgt.tgt_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed test of jk_bank_driver (WIDTH=4, SETTLE=1,
// MAX_RETRY=2) against a behavioural JK flop bank. The flop bank can be
// preloaded, and its q feedback can be forced stuck at zero.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q_in, j_out, k_out, retry_cnt;
  logic       done, err;

  logic [3:0] q_bank   = '0;
  logic       load_req = 1'b0;
  logic [3:0] load_val = '0;
  logic       stuck    = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef JK_TOGGLE_EN
  localparam logic [3:0] SR1_J = 4'b1010, SR1_K = 4'b1010;
  localparam logic [3:0] SR2_J = 4'b1001, SR2_K = 4'b1001;
  localparam logic [3:0] TG_J  = 4'b1010, TG_K  = 4'b1010;
  localparam logic [3:0] RT_K  = 4'b1111;
  localparam logic [3:0] HS_J  = 4'b1001, HS_K  = 4'b1001;
`else
  localparam logic [3:0] SR1_J = 4'b1010, SR1_K = 4'b0000;
  localparam logic [3:0] SR2_J = 4'b0001, SR2_K = 4'b1000;
  localparam logic [3:0] TG_J  = 4'b1000, TG_K  = 4'b0010;
  localparam logic [3:0] RT_K  = 4'b0000;
  localparam logic [3:0] HS_J  = 4'b1001, HS_K  = 4'b0000;
`endif

  jk_bank_driver_if #(.WIDTH(4)) tgt_if ();

  jk_bank_driver #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt       (tgt_if),
    .q_in      (q_in),
    .j_out     (j_out),
    .k_out     (k_out),
    .done      (done),
    .err       (err),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  // JK flop bank: Q+ = J & ~Q | ~K & Q
  always @(posedge clk) begin
    if (load_req) q_bank <= load_val;
    else          q_bank <= (j_out & ~q_bank) | (~k_out & q_bank);
  end

  assign q_in = stuck ? 4'b0000 : q_bank;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] v);
    load_val = v;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_data  = '0;
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    n_cmp++; if (tgt_if.tgt_ready !== 1'b1) begin n_fail++; $display("FAIL por_ready got %b want 1", tgt_if.tgt_ready); end
    n_cmp++; if ({j_out, k_out} !== 8'h00) begin n_fail++; $display("FAIL por_jk got %h want 00", {j_out, k_out}); end
    n_cmp++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL por_done_err got %b want 00", {done, err}); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL por_retry got %0d want 0", retry_cnt); end
    // Reset in the middle of a request
    preload(4'b0000);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = 4'b1111;
    step();
    tgt_if.tgt_valid = 1'b0;
    n_cmp++; if (j_out !== 4'b1111) begin n_fail++; $display("FAIL rst_pre_drive_j got %b want 1111", j_out); end
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    n_cmp++; if (tgt_if.tgt_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b want 1", tgt_if.tgt_ready); end
    n_cmp++; if ({j_out, k_out} !== 8'h00) begin n_fail++; $display("FAIL mid_rst_jk got %h want 00", {j_out, k_out}); end
    n_cmp++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_done_err got %b want 00", {done, err}); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_rst_retry got %0d want 0", retry_cnt); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL abandon_quiet[%0d] got %b want 00", i, {done, err}); end
    end
  endtask

  task automatic test_set_reset();
    preload(4'b0000);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = 4'b1010;
    step();
    tgt_if.tgt_valid = 1'b0;
    n_cmp++; if (j_out !== SR1_J || k_out !== SR1_K) begin n_fail++; $display("FAIL sr1_drive got j=%b k=%b want j=%b k=%b", j_out, k_out, SR1_J, SR1_K); end
    n_cmp++; if (tgt_if.tgt_ready !== 1'b0) begin n_fail++; $display("FAIL sr1_ready_drive got %b want 0", tgt_if.tgt_ready); end
    step();
    n_cmp++; if ({j_out, k_out, done, err} !== 10'b0) begin n_fail++; $display("FAIL sr1_check got jk=%h de=%b want 00 00", {j_out, k_out}, {done, err}); end
    step();
    n_cmp++; if ({done, err, tgt_if.tgt_ready} !== 3'b101) begin n_fail++; $display("FAIL sr1_done got done/err/ready=%b want 101", {done, err, tgt_if.tgt_ready}); end
    n_cmp++; if (q_in !== 4'b1010) begin n_fail++; $display("FAIL sr1_q got %b want 1010", q_in); end
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = 4'b0011;
    step();
    tgt_if.tgt_valid = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL sr_done_pulse got %b want 0", done); end
    n_cmp++; if (j_out !== SR2_J || k_out !== SR2_K) begin n_fail++; $display("FAIL sr2_drive got j=%b k=%b want j=%b k=%b", j_out, k_out, SR2_J, SR2_K); end
    step(); step();
    n_cmp++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL sr2_done got %b want 10", {done, err}); end
    n_cmp++; if (q_in !== 4'b0011) begin n_fail++; $display("FAIL sr2_q got %b want 0011", q_in); end
  endtask

  task automatic test_toggle();
    preload(4'b0110);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = 4'b1100;
    step();
    tgt_if.tgt_valid = 1'b0;
    n_cmp++; if (j_out !== TG_J || k_out !== TG_K) begin n_fail++; $display("FAIL tg_drive got j=%b k=%b want j=%b k=%b", j_out, k_out, TG_J, TG_K); end
    step(); step();
    n_cmp++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL tg_done got %b want 10", {done, err}); end
    n_cmp++; if (q_in !== 4'b1100) begin n_fail++; $display("FAIL tg_q got %b want 1100", q_in); end
  endtask

  task automatic test_hold();
    preload(4'b0101);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = 4'b0101;
    step();
    tgt_if.tgt_valid = 1'b0;
    n_cmp++; if ({j_out, k_out} !== 8'h00) begin n_fail++; $display("FAIL hold_drive got %h want 00", {j_out, k_out}); end
    n_cmp++; if (tgt_if.tgt_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready got %b want 0", tgt_if.tgt_ready); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL hold_early_done got %b want 0", done); end
    step();
    n_cmp++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL hold_done got %b want 10", {done, err}); end
    n_cmp++; if (q_in !== 4'b0101) begin n_fail++; $display("FAIL hold_q got %b want 0101", q_in); end
  endtask

  task automatic test_retry_error();
    stuck = 1'b1;
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = 4'b1111;
    step();
    tgt_if.tgt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (j_out !== 4'b1111 || k_out !== RT_K) begin n_fail++; $display("FAIL rt_drive[%0d] got j=%b k=%b want j=1111 k=%b", i, j_out, k_out, RT_K); end
      n_cmp++; if (retry_cnt !== 4'(i)) begin n_fail++; $display("FAIL rt_cnt[%0d] got %0d want %0d", i, retry_cnt, i); end
      step();
      n_cmp++; if ({j_out, k_out, done, err, tgt_if.tgt_ready} !== 11'b0) begin n_fail++; $display("FAIL rt_check[%0d] got jk=%h d/e/r=%b want 00 000", i, {j_out, k_out}, {done, err, tgt_if.tgt_ready}); end
      step();
    end
    n_cmp++; if ({done, err, tgt_if.tgt_ready} !== 3'b011) begin n_fail++; $display("FAIL rt_err got done/err/ready=%b want 011", {done, err, tgt_if.tgt_ready}); end
    n_cmp++; if (retry_cnt !== 4'd2) begin n_fail++; $display("FAIL rt_final_cnt got %0d want 2", retry_cnt); end
    step();
    n_cmp++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL rt_err_pulse got %b want 00", {done, err}); end
    n_cmp++; if (retry_cnt !== 4'd2) begin n_fail++; $display("FAIL rt_cnt_hold got %0d want 2", retry_cnt); end
    stuck = 1'b0;
  endtask

  task automatic test_handshake();
    preload(4'b0000);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_data  = 4'b0110;
    step();
    tgt_if.tgt_data  = 4'b1001;
    n_cmp++; if (tgt_if.tgt_ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_drive got %b want 0", tgt_if.tgt_ready); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL hs_cnt_cleared got %0d want 0", retry_cnt); end
    step();
    tgt_if.tgt_data  = 4'b1111;
    n_cmp++; if (tgt_if.tgt_ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_check got %b want 0", tgt_if.tgt_ready); end
    step();
    n_cmp++; if ({done, err, tgt_if.tgt_ready} !== 3'b101) begin n_fail++; $display("FAIL hs_done got done/err/ready=%b want 101", {done, err, tgt_if.tgt_ready}); end
    n_cmp++; if (q_in !== 4'b0110) begin n_fail++; $display("FAIL hs_q got %b want 0110", q_in); end
    // valid still high: back-to-back accept at the edge ending the done cycle
    step();
    tgt_if.tgt_valid = 1'b0;
    n_cmp++; if (j_out !== HS_J || k_out !== HS_K) begin n_fail++; $display("FAIL b2b_drive got j=%b k=%b want j=%b k=%b", j_out, k_out, HS_J, HS_K); end
    n_cmp++; if (tgt_if.tgt_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got %b want 0", tgt_if.tgt_ready); end
    step(); step();
    n_cmp++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL b2b_done got %b want 10", {done, err}); end
    n_cmp++; if (q_in !== 4'b1111) begin n_fail++; $display("FAIL b2b_q got %b want 1111", q_in); end
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_toggle();
    test_hold();
    test_retry_error();
    test_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
